x1spi_resp: RTL

Single-lane (x1) SPI mode-0 responder that sits on the far end of our x1 flash-command master and emulates a serial-flash target. It oversamples `sclk`, `cs_n` and `mosi` in the system clock domain and decodes the command byte, the 24-bit address and the dummy bytes. It returns read data on `miso` MSB-first and fetches each byte from a local data source through a request/data handshake. It is the bench and loopback target for the master and the front end of the flash model.

---
 rtl/x1spi_resp.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/x1spi_resp.sv
// Single-lane SPI mode-0 responder emulating a serial-flash target.
// Pins are oversampled in the clk domain; read bytes come from a request/data handshake.
module x1spi_resp #(
  parameter int         FAST_DUMMY = 1,
  parameter logic [7:0] ID_BYTE    = 8'hEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  output logic        busy,
  output logic [7:0]  cmd,
  output logic        cmd_valid,
  output logic [23:0] addr,
  output logic        addr_valid,
  output logic        data_req,
  input  logic [7:0]  tx_data
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DUMMY  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;

  localparam logic [2:0] DUMMY_LAST = 3'(FAST_DUMMY - 1);

  logic        sclk_s1_reg, sclk_s2_reg, sclk_s3_reg;
  logic        cs_s1_reg, cs_s2_reg, cs_s3_reg;
  logic        mosi_s1_reg, mosi_s2_reg;
  logic        valid_reg, armed_reg;
  logic [2:0]  state_reg;
  logic [2:0]  bit_cnt_reg, byte_cnt_reg;
  logic [22:0] sh_reg;
  logic [7:0]  tx_sh_reg;
  logic        req_d1_reg;
  logic        miso_reg, miso_oe_reg;
  logic [7:0]  cmd_reg;
  logic        cmd_valid_reg, addr_valid_reg, data_req_reg;
  logic [23:0] addr_reg;

  logic        cs_rise, cs_fall, sclk_rise, sclk_fall;
  logic [7:0]  cmd_in;
  logic [23:0] addr_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1_reg <= 1'b0; sclk_s2_reg <= 1'b0; sclk_s3_reg <= 1'b0;
      cs_s1_reg   <= 1'b1; cs_s2_reg   <= 1'b1; cs_s3_reg   <= 1'b1;
      mosi_s1_reg <= 1'b0; mosi_s2_reg <= 1'b0;
    end else begin
      sclk_s1_reg <= sclk;  sclk_s2_reg <= sclk_s1_reg; sclk_s3_reg <= sclk_s2_reg;
      cs_s1_reg   <= cs_n;  cs_s2_reg   <= cs_s1_reg;   cs_s3_reg   <= cs_s2_reg;
      mosi_s1_reg <= mosi;  mosi_s2_reg <= mosi_s1_reg;
    end
  end

  // A cs_n fall only counts once cs_n has been seen high after reset (armed_reg).
  assign cs_rise   = cs_s2_reg & ~cs_s3_reg;
  assign cs_fall   = ~cs_s2_reg & cs_s3_reg & armed_reg;
  assign sclk_rise = sclk_s2_reg & ~sclk_s3_reg & ~cs_s2_reg;
  assign sclk_fall = ~sclk_s2_reg & sclk_s3_reg & ~cs_s2_reg;
  assign cmd_in    = {sh_reg[6:0], mosi_s2_reg};
  assign addr_in   = {sh_reg, mosi_s2_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg      <= 1'b0;
      armed_reg      <= 1'b0;
      state_reg      <= ST_IDLE;
      bit_cnt_reg    <= 3'd0;
      byte_cnt_reg   <= 3'd0;
      sh_reg         <= 23'd0;
      tx_sh_reg      <= 8'd0;
      req_d1_reg     <= 1'b0;
      miso_reg       <= 1'b0;
      miso_oe_reg    <= 1'b0;
      cmd_reg        <= 8'h00;
      cmd_valid_reg  <= 1'b0;
      addr_reg       <= 24'h0;
      addr_valid_reg <= 1'b0;
      data_req_reg   <= 1'b0;
    end else begin
      cmd_valid_reg  <= 1'b0;
      addr_valid_reg <= 1'b0;
      data_req_reg   <= 1'b0;
      req_d1_reg     <= data_req_reg;
      valid_reg      <= 1'b1;
      if (valid_reg && cs_s1_reg) armed_reg <= 1'b1;
      if (cs_rise) begin
        state_reg    <= ST_IDLE;
        bit_cnt_reg  <= 3'd0;
        byte_cnt_reg <= 3'd0;
        miso_reg     <= 1'b0;
        miso_oe_reg  <= 1'b0;
        req_d1_reg   <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (cs_fall) begin
              state_reg    <= ST_CMD;
              bit_cnt_reg  <= 3'd0;
              byte_cnt_reg <= 3'd0;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              sh_reg      <= addr_in[22:0];
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) begin
                cmd_reg       <= cmd_in;
                cmd_valid_reg <= 1'b1;
                byte_cnt_reg  <= 3'd0;
                case (cmd_in)
                  8'h03, 8'h0B: state_reg <= ST_ADDR;
                  8'h9F, 8'h05: begin
                    state_reg    <= ST_DATA;
                    data_req_reg <= 1'b1;
                  end
                  default: state_reg <= ST_IGNORE;
                endcase
              end
            end
          end
          ST_ADDR: begin
            if (sclk_rise) begin
              sh_reg      <= addr_in[22:0];
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) begin
                if (byte_cnt_reg == 3'd2) begin
                  addr_reg       <= addr_in;
                  addr_valid_reg <= 1'b1;
                  byte_cnt_reg   <= 3'd0;
                  if (cmd_reg == 8'h0B) begin
                    state_reg <= ST_DUMMY;
                  end else begin
                    state_reg    <= ST_DATA;
                    data_req_reg <= 1'b1;
                  end
                end else begin
                  byte_cnt_reg <= byte_cnt_reg + 3'd1;
                end
              end
            end
          end
          ST_DUMMY: begin
            if (sclk_rise) begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) begin
                if (byte_cnt_reg == DUMMY_LAST) begin
                  state_reg    <= ST_DATA;
                  data_req_reg <= 1'b1;
                  byte_cnt_reg <= 3'd0;
                end else begin
                  byte_cnt_reg <= byte_cnt_reg + 3'd1;
                end
              end
            end
          end
          ST_DATA: begin
            if (sclk_fall) begin
              miso_reg  <= tx_sh_reg[7];
              tx_sh_reg <= {tx_sh_reg[6:0], 1'b0};
            end
            // Byte fetched by the previous data_req lands 2 clk after it.
            if (req_d1_reg) begin
              tx_sh_reg   <= (cmd_reg == 8'h9F) ? ID_BYTE : tx_data;
              miso_oe_reg <= 1'b1;
            end
            if (sclk_rise) begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) begin
                data_req_reg <= 1'b1;
                byte_cnt_reg <= byte_cnt_reg + 3'd1;
                if (cmd_reg == 8'h03 || cmd_reg == 8'h0B) addr_reg <= addr_reg + 24'd1;
              end
            end
          end
          ST_IGNORE: ;
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign miso       = miso_reg;
  assign miso_oe    = miso_oe_reg;
  assign busy       = ~cs_s2_reg & armed_reg;
  assign cmd        = cmd_reg;
  assign cmd_valid  = cmd_valid_reg;
  assign addr       = addr_reg;
  assign addr_valid = addr_valid_reg;
  assign data_req   = data_req_reg;

endmodule
